// File: rtl/pll_reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer_pkg
//
// Shared types and helpers for the PLL reset sequencer:
//   state_t       - sequencer states, in the order the sequencer walks them
//   LOSS_CNT_W    - width of the saturating lock-loss counter
//   LOSS_CNT_MAX  - saturation value of that counter
//   cnt_width()   - bits needed for a counter that runs 0 .. n-1
// ---------------------------------------------------------------------------
package pll_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD_RST  = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

    // A counter with n distinct values (0 .. n-1) needs clog2(n) bits, but
    // never fewer than one so that n = 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer_if
//
// Bundles the lock-status inputs and the reset/tick/loss outputs of the
// sequencer. clk and rst are kept outside the bundle as plain ports.
//   pll_locked     - PLL locked flag (asynchronous to clk)
//   clr_lost       - single-cycle clear of the loss record
//   sys_rst        - registered active-high system reset
//   ready          - registered, high only while the sequencer runs
//   tick           - one-cycle pulse every DIV cycles while running
//   lock_lost      - sticky flag: lock dropped while running
//   lock_loss_cnt  - saturating count of lock drops while running
//
// master: the side that owns the PLL flag and consumes the reset (bench).
// slave : the sequencer itself.
// ---------------------------------------------------------------------------
interface pll_reset_sequencer_if;
    import pll_reset_sequencer_pkg::*;

    logic                  pll_locked;
    logic                  clr_lost;
    logic                  sys_rst;
    logic                  ready;
    logic                  tick;
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;

    modport master (
        output pll_locked,
        output clr_lost,
        input  sys_rst,
        input  ready,
        input  tick,
        input  lock_lost,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_locked,
        input  clr_lost,
        output sys_rst,
        output ready,
        output tick,
        output lock_lost,
        output lock_loss_cnt
    );

endinterface

// File: rtl/pll_reset_sequencer_sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
//
// Multi-flop synchronizer for a single asynchronous level.
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears every stage to 0
//   d    - asynchronous input level
//   q    - synchronized level, SYNC_STAGES clock edges behind d
// ---------------------------------------------------------------------------
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Clocked by the PLL output. Synchronizes the PLL locked flag, waits for it
// to stay high for LOCK_STABLE_CYCLES, holds the system reset for a further
// RST_HOLD_CYCLES, then releases reset and enters RUN. In RUN it emits a
// one-cycle tick every CLK_HZ/TICK_HZ cycles. Any drop of lock while in RUN
// re-asserts reset and is recorded in a sticky flag and a saturating count.
//
// Ports:
//   clk  - PLL outclk_0, all logic on the rising edge
//   rst  - synchronous active-high reset, overrides everything
//   bus  - slave side of pll_reset_sequencer_if (lock flag in, clr_lost in,
//          sys_rst / ready / tick / lock_lost / lock_loss_cnt out)
//
// Every output is a flop; outputs are loaded from next-state values so that
// they change on the same edge as the state they describe.
// ---------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int CLK_HZ             = 16000000,
    parameter int TICK_HZ            = 1000,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.slave  bus
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int SEQ_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_W   = cnt_width(SEQ_MAX);
    localparam int DIV_W   = cnt_width(DIV);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == LOSS_CNT_MAX) ? v : v + LOSS_CNT_W'(1);
    endfunction

    logic                  locked_s;
    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_next;
    logic                  sys_rst_next;
    logic                  ready_next;
    logic                  tick_next;
    logic                  lost_next;
    logic [LOSS_CNT_W-1:0] loss_cnt_next;
    logic                  stay_run;
    logic                  loss;

    // The FSM only ever looks at the synchronized flag.
    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk (clk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; cnt is shared between the STABLE and HOLD_RST phases
    // and restarts from zero on entry to each of them.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = HOLD_RST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HOLD_RST: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: values the output flops take on this edge.
    always_comb begin
        sys_rst_next  = (state_next != RUN);
        ready_next    = (state_next == RUN);

        // The divider only advances while RUN is both the current and the
        // next state, so it is zero on the RUN entry edge and on any exit.
        stay_run      = (state == RUN) && (state_next == RUN);
        tick_next     = stay_run && (div_cnt == DIV_LAST);
        div_next      = '0;
        if (stay_run && (div_cnt != DIV_LAST)) begin
            div_next = div_cnt + DIV_W'(1);
        end

        // A loss recorded on the same edge as clr_lost takes priority and
        // leaves a count of exactly one.
        loss          = (state == RUN) && !locked_s;
        lost_next     = bus.lock_lost;
        loss_cnt_next = bus.lock_loss_cnt;
        if (loss) begin
            lost_next     = 1'b1;
            loss_cnt_next = bus.clr_lost ? LOSS_CNT_W'(1) : sat_inc(bus.lock_loss_cnt);
        end else if (bus.clr_lost) begin
            lost_next     = 1'b0;
            loss_cnt_next = '0;
        end
    end

    // Output and divider registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt           <= '0;
            bus.sys_rst       <= 1'b1;
            bus.ready         <= 1'b0;
            bus.tick          <= 1'b0;
            bus.lock_lost     <= 1'b0;
            bus.lock_loss_cnt <= '0;
        end else begin
            div_cnt           <= div_next;
            bus.sys_rst       <= sys_rst_next;
            bus.ready         <= ready_next;
            bus.tick          <= tick_next;
            bus.lock_lost     <= lost_next;
            bus.lock_loss_cnt <= loss_cnt_next;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed scenarios plus a randomized run, all against a lock-streak model:
// the sequencer is in RUN once the synchronized lock flag has been seen high
// on LOCK_STABLE_CYCLES + RST_HOLD_CYCLES + 1 consecutive edges.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int S       = 2;
    localparam int L       = 8;
    localparam int H       = 4;
    localparam int CLK_HZ  = 16;
    localparam int TICK_HZ = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int RUN_AT  = L + H + 1;     // consecutive locked_s edges to reach RUN
    localparam int RELEASE = 15;            // S+L+H+1 edges from pll_locked high

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .CLK_HZ             (CLK_HZ),
        .TICK_HZ            (TICK_HZ),
        .SYNC_STAGES        (S),
        .LOCK_STABLE_CYCLES (L),
        .RST_HOLD_CYCLES    (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit m_hist[$];   // pll_locked samples still travelling through the synchronizer
    int m_streak;    // consecutive edges the sequencer has seen lock high
    bit m_lost;
    int m_cnt;

    function automatic bit m_run();
        return m_streak >= RUN_AT;
    endfunction

    function automatic bit m_tick();
        int age = m_streak - RUN_AT;
        return (age >= DIV) && ((age % DIV) == 0);
    endfunction

    // Apply inputs, advance one edge, update the model, settle.
    task automatic cycle(input bit pl, input bit clr, input bit r);
        bit ls;
        bit was_run;
        bus.pll_locked = pl;
        bus.clr_lost   = clr;
        rst            = r;
        @(posedge clk);
        if (r) begin
            m_hist = {};
            for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
            m_streak = 0;
            m_lost   = 1'b0;
            m_cnt    = 0;
        end else begin
            ls = m_hist.pop_front();
            m_hist.push_back(pl);
            was_run  = m_run();
            m_streak = ls ? m_streak + 1 : 0;
            if (was_run && !ls) begin
                m_lost = 1'b1;
                m_cnt  = clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
            end else if (clr) begin
                m_lost = 1'b0;
                m_cnt  = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        tests_run++;
        if (bus.sys_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sys_rst: got %b expected 1", bus.sys_rst);
        end
        tests_run++;
        if ({bus.ready, bus.tick, bus.lock_lost} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: ready/tick/lost got %b%b%b expected 000",
                     bus.ready, bus.tick, bus.lock_lost);
        end
        tests_run++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d expected 0", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_power_up();
        for (int e = 1; e <= RELEASE; e++) begin
            cycle(1'b1, 1'b0, 1'b0);
            tests_run++;
            if ({bus.sys_rst, bus.ready, bus.tick} !== {e < RELEASE, e >= RELEASE, 1'b0}) begin
                tests_failed++;
                $display("FAIL power_up edge %0d: sys_rst/ready/tick got %b%b%b expected %b%b0",
                         e, bus.sys_rst, bus.ready, bus.tick, e < RELEASE, e >= RELEASE);
            end
        end
        tests_run++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL power_up_cnt: got %0d expected 0", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_tick();
        for (int k = 1; k <= 13; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            tests_run++;
            if ({bus.tick, bus.sys_rst, bus.ready} !== {(k % DIV) == 0, 2'b01}) begin
                tests_failed++;
                $display("FAIL tick ready+%0d: tick/sys_rst/ready got %b%b%b expected %b01",
                         k, bus.tick, bus.sys_rst, bus.ready, (k % DIV) == 0);
            end
        end
    endtask

    task automatic test_glitch();
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        // pll_locked low only on the sample at edge 6; it is high again from 7.
        for (int e = 1; e <= 22; e++) begin
            cycle(e != 6, 1'b0, 1'b0);
            tests_run++;
            if (bus.sys_rst !== (e < 21)) begin
                tests_failed++;
                $display("FAIL glitch edge %0d: sys_rst got %b expected %b", e, bus.sys_rst, e < 21);
            end
        end
        tests_run++;
        if ({bus.lock_lost, bus.lock_loss_cnt} !== 9'd0) begin
            tests_failed++;
            $display("FAIL glitch_record: lost=%b cnt=%0d expected 0/0", bus.lock_lost, bus.lock_loss_cnt);
        end
    endtask

    task automatic test_loss();
        for (int j = 1; j <= 3; j++) begin
            cycle(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (bus.sys_rst !== (j == 3)) begin
                tests_failed++;
                $display("FAIL loss_edge %0d: sys_rst got %b expected %b", j, bus.sys_rst, j == 3);
            end
        end
        tests_run++;
        if ({bus.ready, bus.tick, bus.lock_lost, bus.lock_loss_cnt} !== {3'b001, 8'd1}) begin
            tests_failed++;
            $display("FAIL loss_record: ready=%b tick=%b lost=%b cnt=%0d expected 0/0/1/1",
                     bus.ready, bus.tick, bus.lock_lost, bus.lock_loss_cnt);
        end
        for (int e = 1; e <= RELEASE; e++) begin
            cycle(1'b1, 1'b0, 1'b0);
            tests_run++;
            if (bus.sys_rst !== (e < RELEASE)) begin
                tests_failed++;
                $display("FAIL relock edge %0d: sys_rst got %b expected %b", e, bus.sys_rst, e < RELEASE);
            end
        end
    endtask

    task automatic test_saturation();
        // One loss is already on record; 260 more must pin the count at 255.
        for (int i = 0; i < 260; i++) begin
            repeat (3) cycle(1'b0, 1'b0, 1'b0);
            if (i == 100) begin
                tests_run++;
                if (bus.lock_loss_cnt !== 8'd102) begin
                    tests_failed++;
                    $display("FAIL sat_mid: got %0d expected 102", bus.lock_loss_cnt);
                end
            end
            repeat (RELEASE) cycle(1'b1, 1'b0, 1'b0);
        end
        tests_run++;
        if ({bus.lock_lost, bus.lock_loss_cnt} !== {1'b1, 8'd255}) begin
            tests_failed++;
            $display("FAIL sat_cnt: lost=%b cnt=%0d expected 1/255", bus.lock_lost, bus.lock_loss_cnt);
        end
        // Loss and clear on the same edge.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({bus.lock_lost, bus.lock_loss_cnt} !== {1'b1, 8'd1}) begin
            tests_failed++;
            $display("FAIL clr_with_loss: lost=%b cnt=%0d expected 1/1", bus.lock_lost, bus.lock_loss_cnt);
        end
        cycle(1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({bus.lock_lost, bus.lock_loss_cnt} !== 9'd0) begin
            tests_failed++;
            $display("FAIL clr_alone: lost=%b cnt=%0d expected 0/0", bus.lock_lost, bus.lock_loss_cnt);
        end
    endtask

    task automatic test_mid_run_rst();
        repeat (RELEASE) cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        repeat (RELEASE) cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({bus.ready, bus.lock_lost, bus.lock_loss_cnt} !== {2'b11, 8'd1}) begin
            tests_failed++;
            $display("FAIL pre_rst: ready=%b lost=%b cnt=%0d expected 1/1/1",
                     bus.ready, bus.lock_lost, bus.lock_loss_cnt);
        end
        cycle(1'b1, 1'b0, 1'b1);
        tests_run++;
        if ({bus.sys_rst, bus.ready, bus.tick, bus.lock_lost, bus.lock_loss_cnt} !== {4'b1000, 8'd0}) begin
            tests_failed++;
            $display("FAIL mid_rst: sys_rst=%b ready=%b tick=%b lost=%b cnt=%0d expected 1/0/0/0/0",
                     bus.sys_rst, bus.ready, bus.tick, bus.lock_lost, bus.lock_loss_cnt);
        end
        for (int e = 1; e <= RELEASE; e++) begin
            cycle(1'b1, 1'b0, 1'b0);
            tests_run++;
            if ({bus.sys_rst, bus.ready} !== {e < RELEASE, e >= RELEASE}) begin
                tests_failed++;
                $display("FAIL after_rst edge %0d: sys_rst/ready got %b%b expected %b%b",
                         e, bus.sys_rst, bus.ready, e < RELEASE, e >= RELEASE);
            end
        end
    endtask

    task automatic test_random();
        int   remaining = 0;
        bit   lvl       = 1'b1;
        logic [11:0] got;
        logic [11:0] exp;
        for (int i = 0; i < 4000; i++) begin
            if (remaining == 0) begin
                lvl       = !lvl;
                remaining = lvl ? $urandom_range(1, 40) : $urandom_range(1, 3);
            end
            remaining--;
            cycle(lvl, $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
            exp = {!m_run(), m_run(), m_tick(), m_lost, 8'(m_cnt)};
            got = {bus.sys_rst, bus.ready, bus.tick, bus.lock_lost, bus.lock_loss_cnt};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random cycle %0d: sys_rst/ready/tick/lost/cnt got %b%b%b%b/%0d expected %b%b%b%b/%0d",
                         i, got[11], got[10], got[9], got[8], got[7:0],
                         exp[11], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_tick();
        test_glitch();
        test_loss();
        test_saturation();
        test_mid_run_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits directly downstream of the 16 MHz PLL wrapper and is clocked by its outclk_0. It synchronizes and qualifies the PLL locked flag and releases a clean synchronous system reset only after lock has been stable. It then generates a periodic one-cycle tick for the lab logic, and records lock-loss events.

Parameters:
CLK_HZ, 16000000, frequency of clk (PLL outclk_0)
TICK_HZ, 1000, tick rate; DIV = CLK_HZ/TICK_HZ (must divide exactly, DIV >= 2)
SYNC_STAGES, 2, flip-flops in the pll_locked synchronizer (>= 2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required (>= 1)
RST_HOLD_CYCLES, 16, extra cycles sys_rst is held after lock qualifies (>= 1)

Ports:
clk  in  1  PLL outclk_0; all logic on the rising edge
rst  in  1  synchronous, active-high reset; overrides all other inputs
pll_locked  in  1  PLL locked flag, asynchronous to clk
clr_lost  in  1  single-cycle clear of lock_lost and lock_loss_cnt
sys_rst  out  1  registered active-high system reset for downstream logic
ready  out  1  registered; 1 only in state RUN
tick  out  1  registered one-cycle pulse every DIV cycles while in RUN
lock_lost  out  1  sticky: lock dropped while in RUN
lock_loss_cnt  out  8  saturating count of lock drops while in RUN

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=WAIT_LOCK, synchronizer=0, all counters=0, sys_rst=1, ready=0, tick=0, lock_lost=0, lock_loss_cnt=0. rst asserted mid-operation takes effect at the next edge, from any state.
- locked_s is the SYNC_STAGES-deep synchronized pll_locked. It is never combinationally bypassed.
- States:
  - WAIT_LOCK: sys_rst=1. If locked_s=1, go to STABLE with cnt=0.
  - STABLE: sys_rst=1. If locked_s=0, go to WAIT_LOCK. Otherwise, if cnt==LOCK_STABLE_CYCLES-1, go to HOLD_RST with cnt=0; else cnt+1.
  - HOLD_RST: sys_rst=1. If locked_s=0, go to WAIT_LOCK. Otherwise, if cnt==RST_HOLD_CYCLES-1, go to RUN; else cnt+1.
  - RUN: sys_rst=0, ready=1. If locked_s=0, go to WAIT_LOCK. On that same edge, sys_rst returns to 1, ready and tick go to 0, and a loss is recorded.
- Release latency: pll_locked is high and stable from edge 0. With S=SYNC_STAGES, L=LOCK_STABLE_CYCLES, H=RST_HOLD_CYCLES, sys_rst falls and ready rises at edge S+L+H+1. A single locked_s glitch at any point before RUN restarts the full count.
- Tick: divider counter is cleared on the RUN entry edge. tick=1 for exactly the cycle after the counter reaches DIV-1, then the counter wraps to 0. The first tick occurs DIV cycles after ready rises. Period is exactly DIV cycles. The divider is frozen and cleared outside RUN.
- Loss record: each RUN->WAIT_LOCK transition sets lock_lost=1 and increments lock_loss_cnt, saturating at 255. Drops of locked_s outside RUN are not counted.
- clr_lost=1 zeroes both lock_lost and lock_loss_cnt at the next edge. If a loss coincides with clr_lost, the loss wins: lock_lost=1, lock_loss_cnt=1.
- All outputs are registered; no output depends combinationally on any input.

Decomposition:
- Shared package: state enum (WAIT_LOCK, STABLE, HOLD_RST, RUN), the 8-bit loss-count width constant, and a function computing counter width via $clog2.
- One sub-module, sync_bit: parameterized SYNC_STAGES flip-flop synchronizer with synchronous active-high reset to 0.
- Tick divider and FSM stay in the top module.

Test Plan (S=2, L=8, H=4, CLK_HZ=16, TICK_HZ=4 so DIV=4):
- Power-up: rst high for 3 cycles, then pll_locked=1 at edge 0 -> sys_rst=1 through edge 14, sys_rst=0 and ready=1 at edge 15; lock_loss_cnt=0.
- Tick timing: after ready rises -> tick=1 at ready+4, +8, +12, each exactly one cycle wide; no tick while sys_rst=1.
- Lock glitch during STABLE: pll_locked low for 1 cycle at edge 6 -> count restarts; release occurs 15 edges after pll_locked returns high; lock_loss_cnt stays 0.
- Loss in RUN: drop pll_locked -> 2 edges later, sys_rst=1, ready=0, tick=0, lock_lost=1, lock_loss_cnt=1. Relock -> re-release after a further 15 edges.
- Saturation and clear: force 260 RUN losses -> lock_loss_cnt=255. clr_lost coincident with a loss -> lock_lost=1, lock_loss_cnt=1. clr_lost alone -> both 0.
- Mid-RUN rst: assert rst for 1 cycle -> next edge sys_rst=1, ready=0, lock_lost=0, lock_loss_cnt=0. With pll_locked held high, release 15 edges after rst deasserts.
